uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter, next generation of the fixed 8N1 serial TX.

---
 rtl/uart_tx_cfg.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload sent LSB first, optional even/odd parity,
// one or two stop bits, valid/ready input handshake.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 ip_Clock,
  input  logic                 ip_Rst_n,
  input  logic                 ip_Tx_DV,
  input  logic [DATA_BITS-1:0] ip_Tx_Data,
  output logic                 op_Tx_Ready,
  output logic                 op_Tx_Active,
  output logic                 op_Tx_Serial,
  output logic                 op_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Even parity is the XOR of the word; odd parity is its complement.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
    return (PARITY == 2) ? ~^word : ^word;
  endfunction

  state_e                 state_q;
  logic [CNT_W-1:0]       clk_cnt_q;
  logic [CNT_W-1:0]       clk_cnt_d;
  logic [3:0]             bit_idx_q;
  logic [3:0]             bit_nxt_s;
  logic [DATA_BITS-1:0]   data_q;
  logic [DATA_BITS-1:0]   data_shift_s;
  logic                   parity_q;
  logic                   bit_end_s;
  logic                   ready_q;
  logic                   active_q;
  logic                   serial_q;
  logic                   done_q;

  // Bit-period counter wrap and the next payload bit to drive.
  always_comb begin
    bit_end_s    = (clk_cnt_q == CNT_LAST);
    clk_cnt_d    = bit_end_s ? {CNT_W{1'b0}} : (clk_cnt_q + CNT_W'(1));
    bit_nxt_s    = bit_idx_q + 4'd1;
    data_shift_s = data_q >> bit_nxt_s;
  end

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge ip_Clock or negedge ip_Rst_n) begin
    if (!ip_Rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 4'd0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      ready_q   <= 1'b1;
      active_q  <= 1'b0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q    <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= 4'd0;
          if (ip_Tx_DV && ready_q) begin
            data_q   <= ip_Tx_Data;
            parity_q <= calc_parity(ip_Tx_Data);
            ready_q  <= 1'b0;
            active_q <= 1'b1;
            serial_q <= 1'b0;
            state_q  <= ST_START;
          end else begin
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            serial_q <= 1'b1;
          end
        end
        ST_START: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end_s) begin
            bit_idx_q <= 4'd0;
            serial_q  <= data_q[0];
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end_s) begin
            if (bit_idx_q == DATA_LAST) begin
              bit_idx_q <= 4'd0;
              if (PARITY != 0) begin
                serial_q <= parity_q;
                state_q  <= ST_PARITY;
              end else begin
                serial_q <= 1'b1;
                state_q  <= ST_STOP;
              end
            end else begin
              bit_idx_q <= bit_nxt_s;
              serial_q  <= data_shift_s[0];
            end
          end
        end
        ST_PARITY: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end_s) begin
            bit_idx_q <= 4'd0;
            serial_q  <= 1'b1;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end_s) begin
            if (bit_idx_q == STOP_LAST) begin
              bit_idx_q <= 4'd0;
              active_q  <= 1'b0;
              done_q    <= 1'b1;
              ready_q   <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              bit_idx_q <= bit_nxt_s;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          clk_cnt_q <= '0;
          bit_idx_q <= 4'd0;
          ready_q   <= 1'b1;
          active_q  <= 1'b0;
          serial_q  <= 1'b1;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign op_Tx_Ready  = ready_q;
  assign op_Tx_Active = active_q;
  assign op_Tx_Serial = serial_q;
  assign op_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four parameter sets run side by side, each checked every cycle
// against a queue of expected line values built from the frame format.
module tb_uart_tx_cfg;

  localparam int C = 4;
  localparam int          DB_T  [4] = '{8, 8, 8, 7};
  localparam int          PA_T  [4] = '{0, 1, 2, 0};
  localparam int          SB_T  [4] = '{1, 1, 1, 2};
  localparam logic [8:0]  DIR_T [4] = '{9'h0A5, 9'h007, 9'h007, 9'h041};
  localparam logic [11:0] EXP_T [4] = '{12'h34A, 12'h60E, 12'h40E, 12'h382};
  localparam int          LAT_T [4] = '{40, 44, 44, 40};

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int gi, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d actual %0h expected %0h at %0t", nm, gi, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DB = DB_T[g];
    localparam int PA = PA_T[g];
    localparam int SB = SB_T[g];
    localparam int NB = 1 + DB + ((PA != 0) ? 1 : 0) + SB;
    localparam int N  = C * NB;

    logic          rst_n = 1'b0;
    logic          dv    = 1'b0;
    logic [DB-1:0] data  = '0;
    logic          rdy, act, ser, done;
    bit            fin_b = 1'b0;
    int            done_cnt = 0;

    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .PARITY(PA), .STOP_BITS(SB)) u_dut (
      .ip_Clock(clk), .ip_Rst_n(rst_n), .ip_Tx_DV(dv), .ip_Tx_Data(data),
      .op_Tx_Ready(rdy), .op_Tx_Active(act), .op_Tx_Serial(ser), .op_Tx_Done(done)
    );

    // Reference model: one queue entry per clock of line level for the frame in flight.
    bit            q[$];
    bit            pend_dv = 1'b0;
    logic [DB-1:0] pend_data = '0;
    bit            exp_done = 1'b0;

    function automatic void push_frame(input logic [DB-1:0] d);
      int ones = $countones(d);
      bit par  = (PA == 2) ? (ones % 2 == 0) : (ones % 2 == 1);
      for (int r = 0; r < C; r++) q.push_back(1'b0);
      for (int i = 0; i < DB; i++)
        for (int r = 0; r < C; r++) q.push_back(d[i]);
      if (PA != 0)
        for (int r = 0; r < C; r++) q.push_back(par);
      for (int r = 0; r < SB * C; r++) q.push_back(1'b1);
    endfunction

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        pend_dv  = 1'b0;
        exp_done = 1'b0;
      end else begin
        exp_done = 1'b0;
        if (q.size() > 0) begin
          void'(q.pop_front());
          if (q.size() == 0) exp_done = 1'b1;
        end else if (pend_dv) begin
          push_frame(pend_data);
        end
        pend_dv   = dv;
        pend_data = data;
      end
      done_cnt += int'(done);
      chk("serial", g, 32'(ser),  (q.size() > 0) ? 32'(q[0]) : 32'd1);
      chk("active", g, 32'(act),  (q.size() > 0) ? 32'd1 : 32'd0);
      chk("ready",  g, 32'(rdy),  (q.size() > 0) ? 32'd0 : 32'd1);
      chk("done",   g, 32'(done), 32'(exp_done));
    end

    task automatic tick();
      @(posedge clk);
      #2;
    endtask

    initial begin : drive
      logic [11:0] got;
      int lat, act_n, d0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // Single frame with hand-computed line pattern and timing.
      dv = 1'b1; data = DB'(DIR_T[g]);
      @(posedge clk); #2 dv = 1'b0;
      got = '0; lat = -1; act_n = 0;
      for (int k = 0; k < N + 4; k++) begin
        @(negedge clk);
        act_n += int'(act);
        if (lat < 0 && done) lat = k;
        for (int j = 0; j < NB; j++)
          if (k == j * C + 1) got = got | (12'(ser) << j);
      end
      chk("frame bits", g, 32'(got), 32'(EXP_T[g]));
      chk("done latency", g, lat, LAT_T[g]);
      chk("active cycles", g, act_n, LAT_T[g]);
      tick();

      // DV held high across two frames; data switched while the first is on the line.
      d0 = done_cnt;
      dv = 1'b1; data = DB'(9'h055);
      @(posedge clk); #2 data = DB'(9'h0AA);
      repeat (N + 1) tick();
      dv = 1'b0;
      repeat (N + 4) tick();
      chk("b2b done count", g, done_cnt - d0, 2);

      // DV pulse with all-ones during data bit 3 of an all-zero frame.
      d0 = done_cnt;
      dv = 1'b1; data = '0;
      @(posedge clk); #2 dv = 1'b0;
      repeat (4 * C) tick();
      dv = 1'b1; data = '1;
      tick();
      dv = 1'b0;
      repeat (N + 4) tick();
      chk("ignored dv done count", g, done_cnt - d0, 1);

      // Reset in the middle of a data bit, then a clean frame.
      dv = 1'b1; data = DB'($urandom);
      @(posedge clk); #2 dv = 1'b0;
      repeat (2 * C) tick();
      rst_n = 1'b0;
      #1;
      chk("reset serial", g, 32'(ser), 32'd1);
      chk("reset active", g, 32'(act), 32'd0);
      chk("reset ready",  g, 32'(rdy), 32'd1);
      tick(); tick();
      rst_n = 1'b1;
      d0 = done_cnt;
      dv = 1'b1; data = DB'(9'h03C);
      @(posedge clk); #2 dv = 1'b0;
      repeat (N + 4) tick();
      chk("post-reset done count", g, done_cnt - d0, 1);

      // Random traffic: sparse DV, new data every cycle.
      repeat (800) begin
        dv   = ($urandom_range(0, 3) == 0);
        data = DB'($urandom);
        tick();
      end
      dv = 1'b0;
      repeat (N + 4) tick();
      fin_b = 1'b1;
    end
  end

  initial begin : main
    int cyc = 0;
    while (!(g_cfg[0].fin_b && g_cfg[1].fin_b && g_cfg[2].fin_b && g_cfg[3].fin_b) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (!(g_cfg[0].fin_b && g_cfg[1].fin_b && g_cfg[2].fin_b && g_cfg[3].fin_b)) begin
      errors++;
      $display("FAIL timeout actual %0d cycles without completion", cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
